// File: rtl/rsa_pkg.sv
// Shared types and helpers for the parametrised modular-exponentiation engine.
// Imported by the top level and by the serial modular multiplier.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    UPDATE,
    FIN,
    ERR
  } state_e;

  localparam int unsigned ONE = 1;

  // Cycles from the edge sampling go to the edge raising done, valid operands.
  function automatic int lat(input int width, input int exp_width);
    return 2 + exp_width * (width + 1);
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Interleaved MSB-first modular multiplier: p = a*b mod m for a,b < m.
// The first bit is consumed on the start edge, so p is final WIDTH cycles later.
module mod_mul_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] p,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = WIDTH + 2;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d, p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             act_q, act_d;

  // 2P + b < 3m, so two guarded subtracts restore P < m; PW bits hold 3m.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] acc,
                                            input logic             a_bit,
                                            input logic [WIDTH-1:0] bv,
                                            input logic [WIDTH-1:0] mv);
    logic [PW-1:0] t;
    t = {1'b0, acc, 1'b0} + (a_bit ? {2'b00, bv} : '0);
    if (t >= {2'b00, mv}) t = t - {2'b00, mv};
    if (t >= {2'b00, mv}) t = t - {2'b00, mv};
    return WIDTH'(t);
  endfunction

  // Kept out of the always_comb so the parent's operand mux never sees a loop.
  assign done = act_q && (cnt_q == '0);
  assign p    = p_q;

  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first; this prevents latches and keeps simulation equal to synthesis.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    m_d   = m_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    act_d = act_q;
    if (start) begin
      p_d   = step('0, a[WIDTH-1], b, m);
      a_d   = a << 1;
      b_d   = b;
      m_d   = m;
      cnt_d = CW'(WIDTH - 1);
      act_d = 1'b1;
    end else if (act_q) begin
      if (cnt_q != '0) begin
        p_d   = step(p_q, a_q[WIDTH-1], b_q, m_q);
        a_d   = a_q << 1;
        cnt_d = cnt_q - 1'b1;
      end else begin
        act_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      m_q   <= m_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

endmodule

// File: rtl/rsa_modexp_param.sv
// Constant-time right-to-left modular exponentiation: result = base^exponent mod modulus.
// Two serial multipliers compute R*B and B*B in parallel for every exponent bit.
module rsa_modexp_param
  import rsa_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 err
);

  localparam int IT_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  state_e               state_q, state_d;
  logic [IT_W-1:0]      it_q, it_d;
  logic [WIDTH-1:0]     r_q, r_d, b_q, b_d, mod_q, mod_d, result_q, result_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic                 done_q, done_d, busy_q, busy_d, err_q, err_d;
  logic                 mul_start;
  logic [WIDTH-1:0]     m1_p, m2_p;
  logic                 m1_done, m2_done;

  // Multipliers read the next-state R/B so a start in UPDATE uses fresh operands.
  mod_mul_serial #(.WIDTH(WIDTH)) u_mul_rb (
    .clk(clk), .rst_n(reset), .start(mul_start),
    .a(r_d), .b(b_d), .m(mod_q), .p(m1_p), .done(m1_done)
  );

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul_bb (
    .clk(clk), .rst_n(reset), .start(mul_start),
    .a(b_d), .b(b_d), .m(mod_q), .p(m2_p), .done(m2_done)
  );

  always_comb begin
    state_d   = state_q;
    it_d      = it_q;
    r_d       = r_q;
    b_d       = b_q;
    e_d       = e_q;
    mod_d     = mod_q;
    result_d  = result_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    err_d     = err_q;
    mul_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          if ((modulus < WIDTH'(2)) || (base >= modulus)) begin
            state_d = ERR;
          end else begin
            b_d     = base;
            e_d     = exponent;
            mod_d   = modulus;
            busy_d  = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        r_d       = WIDTH'(ONE);
        it_d      = '0;
        mul_start = 1'b1;
        state_d   = MUL;
      end
      MUL: begin
        if (m1_done && m2_done) state_d = UPDATE;
      end
      UPDATE: begin
        if (e_q[0]) r_d = m1_p;
        b_d = m2_p;
        e_d = e_q >> 1;
        if (it_q == IT_W'(EXP_WIDTH - 1)) begin
          state_d = FIN;
        end else begin
          it_d      = it_q + 1'b1;
          mul_start = 1'b1;
          state_d   = MUL;
        end
      end
      FIN: begin
        result_d = r_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        err_d    = 1'b0;
        state_d  = IDLE;
      end
      ERR: begin
        result_d = '0;
        err_d    = 1'b1;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      it_q     <= '0;
      r_q      <= '0;
      b_q      <= '0;
      e_q      <= '0;
      mod_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      it_q     <= it_d;
      r_q      <= r_d;
      b_q      <= b_d;
      e_q      <= e_d;
      mod_q    <= mod_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule

// File: doc/rsa_modexp_param.md
Name: rsa_modexp_param

Overview:
- Parametrised modular-exponentiation engine. Computes result = base^exponent mod modulus.
- Successor to the fixed 32-bit RSA core used on the RFID path. Adds generic operand widths, a busy output and an operand-error flag.
- Uses a constant-time schedule: every exponent bit is processed regardless of value, so latency does not depend on the key.
- Sits between the RFID frame buffer and the key store. It is started by a one-cycle go and answers with a one-cycle done.

Parameters:
WIDTH, 32, width of base, modulus, result
EXP_WIDTH, 32, width of exponent; number of square/multiply iterations

Ports:
clk  in  1  rising-edge system clock
reset  in  1  asynchronous, active-low reset (reset=0 clears the block)
go  in  1  start pulse; operands sampled on the edge where go=1 and busy=0
base  in  WIDTH  message/ciphertext, must be < modulus
exponent  in  EXP_WIDTH  public or private key
modulus  in  WIDTH  modulus, must be >= 2
result  out  WIDTH  exponentiation result, held until the next accepted go
done  out  1  one-cycle pulse: result/err valid
busy  out  1  high from the cycle after go is accepted until done
err  out  1  operand error; valid with done, held until the next accepted go

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; result=0, done=0, busy=0, err=0; all internal registers 0.
- Reset deasserts synchronously to clk in the system. Reset mid-operation aborts with no done.
- Algorithm: right-to-left binary exponentiation.
  - Registers: R (accumulator, init 1), B (running square, init base), E (exponent shift register).
  - Per iteration, two mod_mul_serial instances run in parallel on the same start:
    - M1 = R*B mod m
    - M2 = B*B mod m
  - In UPDATE: if E[0]=1 then R<=M1; B<=M2 always; E<=E>>1.
  - Iteration counter counts to EXP_WIDTH. Leading zero bits are not skipped.
- States:
  - IDLE: busy=0. On go:
    - If modulus<2 or base>=modulus: go to ERR.
    - Else latch operands and go to LOAD.
    - go while busy=1 is ignored.
  - LOAD: 1 cycle. R<=1, B<=base, E<=exponent, iteration count<=0, pulse start to both multipliers. Go to MUL.
  - MUL: WIDTH cycles. Wait for multiplier done; both finish on the same cycle. Go to UPDATE.
  - UPDATE: 1 cycle. Register update as above.
    - If count=EXP_WIDTH-1: go to FIN.
    - Else count+1, pulse start, go to MUL.
  - FIN: result<=R, done=1 for exactly 1 cycle, busy=0, err=0. Go to IDLE.
  - ERR: result<=0, err<=1, done=1 for 1 cycle. Go to IDLE.
- Latency:
  - Valid operands: from the edge sampling go to the edge raising done is LAT = 2 + EXP_WIDTH*(WIDTH+1). Default 1058 cycles.
  - Error case: done rises 1 edge after go.
- Boundaries:
  - exponent=0 gives result=1.
  - base=0 with exponent>0 gives result=0.
  - base=0 with exponent=0 gives result=1.
  - Maximum operands (modulus=2^WIDTH-1) must not overflow; see the sub-module.
  - go on the same cycle as done is accepted only from IDLE, i.e. on the following cycle.
- mod_mul_serial (a*b mod m, a,b < m), interleaved and MSB-first over a:
  - Accumulator P is WIDTH+2 bits, cleared on start.
  - Each cycle: P = 2P + (a_i ? b : 0), then conditional subtract of m up to twice, leaving P < m.
  - Exactly WIDTH cycles after start; done pulses on the last cycle with product valid.

Decomposition:
- Shared package rsa_pkg holds:
  - the state enum {IDLE, LOAD, MUL, UPDATE, FIN, ERR};
  - a latency function lat(WIDTH, EXP_WIDTH);
  - constant ONE.
- One sub-module, mod_mul_serial (parameter WIDTH), instantiated twice.
- The top level holds the FSM, iteration counter and E/R/B registers.

Test Plan:
- WIDTH=32, EXP_WIDTH=32; base=4, exponent=13, modulus=497, go pulse -> done exactly 1058 cycles later, result=445, err=0, busy high throughout.
- base=2, exponent=10, modulus=1000 -> result=24. Then base=7, exponent=0, modulus=13 -> result=1, same 1058-cycle latency.
- modulus=32'hFFFFFFFF:
  - base=32'hFFFFFFFE, exponent=2 -> result=1.
  - exponent=3 -> result=32'hFFFFFFFE (no overflow in the P accumulator).
- modulus=1, or base=600 with modulus=497 -> done 1 cycle after go, err=1, result=0, busy never high.
- Start 4^13 mod 497, pulse go with other operands at cycle 200 -> ignored; result still 445 at cycle 1058.
- Pull reset low at cycle 500 -> outputs 0 immediately, no done. After release, a new go completes normally.
